// File: rtl/uart_rx_framer.sv
// -----------------------------------------------------------------------------
// uart_rx_framer
//   Receives 8N1 frames (8 data bits, LSB first, 1 stop bit) from an
//   asynchronous RS-232 line and reports each correctly framed byte.
//   With UART_RX_PARITY_EN defined, the frame carries an even parity bit
//   between bit 7 and the stop bit (8E1).
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit time (4..8191), default 5208.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rs232_rx    serial line, idle high
//   rx_data     last good byte, held until the next good frame
//   rx_valid    1-cycle pulse when rx_data updates
//   rx_int      high while a frame is in progress; falls at frame end
//   frame_err   1-cycle pulse: stop bit sampled low
//   parity_err  1-cycle pulse: even parity mismatch (0 without parity)
//
// Build option
//   UART_RX_PARITY_EN  adds the PARITY state and parity checking.
// -----------------------------------------------------------------------------
module uart_rx_framer #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_int,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [12:0] HALF_BIT = 13'(CLKS_PER_BIT / 2);
    localparam logic [12:0] LAST_CNT = 13'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_int_q, rx_int_d;
    logic        frame_err_q, frame_err_d;

    // Synchronizer plus edge-detect history.
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]  fill_q;
    logic        fall;

    // rx_prev_q only takes real line values once both synchronizer stages
    // hold post-reset samples (fill_q[1]); the reset value of 1 in the
    // synchronizer therefore never fakes a 1->0 edge for a line that is
    // already low when reset releases.
    assign fall = rx_prev_q & ~rx_sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its sources, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b0;
            fill_q    <= 2'b00;
        end else begin
            rx_meta_q <= rs232_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q & fill_q[1];
            fill_q    <= {fill_q[0], 1'b1};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_err_q, parity_err_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q + 13'd1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_int_d    = rx_int_q;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d  = START;
                    rx_int_d = 1'b1;
                end
            end
            START: begin
                if (cnt_q == HALF_BIT) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (rx_sync_q) begin
                        state_d  = IDLE;   // glitch, not a start bit
                        rx_int_d = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shift_q, rx_sync_q};   // even parity
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    rx_int_d = 1'b0;
                    if (rx_sync_q) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end
`else
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                // Line held low after a bad stop bit: wait for idle before
                // any new start detection.
                cnt_d = '0;
                if (rx_sync_q) state_d = IDLE;
            end
            default: begin
                cnt_d    = '0;
                rx_int_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_int_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_int_q    <= rx_int_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_int    = rx_int_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_framer
//   Directed bench for uart_rx_framer at CLKS_PER_BIT=16. Stimulus pushes the
//   expected output events into a queue; an independent monitor pops and
//   compares whenever the DUT pulses rx_valid, frame_err or parity_err.
//   The monitor also measures how long each rx_int high phase lasts.
// -----------------------------------------------------------------------------
module tb_uart_rx_framer;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_INT_LEN = 169;   // 8 + 10*16 + 1
`else
    localparam int FRAME_INT_LEN = 153;   // 8 + 9*16 + 1
`endif
    localparam int GLITCH_INT_LEN = 9;    // START cycles 0..8, leaves at half bit

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_int;
    logic       frame_err;
    logic       parity_err;

    uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs232_rx   (rs232_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_int     (rx_int),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_VALID, EV_FERR, EV_PERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  int_run = 0;
    int  last_int_len = 0;
    int  int_high_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        ev_t        e;
        logic [2:0] exp_flags;
        if (rx_int) begin
            int_run++;
            int_high_total++;
        end else if (int_run != 0) begin
            last_int_len = int_run;
            int_run = 0;
        end
        if (rx_valid || frame_err || parity_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    EV_VALID: exp_flags = 3'b100;
                    EV_FERR:  exp_flags = 3'b010;
                    default:  exp_flags = 3'b001;
                endcase
                check("event_flags", {29'd0, rx_valid, frame_err, parity_err}, {29'd0, exp_flags});
                check("rx_int_low_at_frame_end", {31'd0, rx_int}, 32'd0);
                if (e.kind == EV_VALID) check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            end
        end
    end

    // NOTE: stimulus is driven with blocking assignments right after the
    // falling edge, so the DUT never sees it change at its sampling edge.
    task automatic drive(input logic b, input int n);
        rs232_rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive(par_b, CPB);
`else
        if (par_b === 1'bx) drive(1'b1, 0);
`endif
        drive(stop_b, CPB);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"},    {24'd0, rx_data}, 32'd0);
        check({tag, "_rx_valid"},   {31'd0, rx_valid}, 32'd0);
        check({tag, "_rx_int"},     {31'd0, rx_int}, 32'd0);
        check({tag, "_frame_err"},  {31'd0, frame_err}, 32'd0);
        check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int snap;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        drive(1'b1, 10);

        // Good frame 8'hA5 (even parity bit 0)
        expect_ev(EV_VALID, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        drive(1'b1, 8);
        wait_drain("a5_drain");
        check("a5_rx_int_len", last_int_len, FRAME_INT_LEN);
        check("a5_rx_data_held", {24'd0, rx_data}, 32'h0000_00A5);

        // 5-cycle glitch: rejected at the half-bit sample
        drive(1'b0, 5);
        drive(1'b1, 30);
        check("glitch_rx_int_len", last_int_len, GLITCH_INT_LEN);
        check("glitch_rx_int_low", {31'd0, rx_int}, 32'd0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'h0000_00A5);

        // 8'h3C with bad stop bit, line low 40 cycles from stop bit start
        expect_ev(EV_FERR, 8'h00);
        snap = int_high_total;
        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 24);
        check("ferr_rx_int_len", last_int_len, FRAME_INT_LEN);
        check("ferr_no_restart_low", int_high_total - snap, FRAME_INT_LEN);
        check("ferr_rx_data_kept", {24'd0, rx_data}, 32'h0000_00A5);
        drive(1'b1, 20);
        check("ferr_no_restart_high", int_high_total - snap, FRAME_INT_LEN);
        wait_drain("ferr_drain");

        // Back-to-back 8'h00 then 8'hFF, zero idle gap
        expect_ev(EV_VALID, 8'h00);
        expect_ev(EV_VALID, 8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive(1'b1, 10);
        wait_drain("b2b_drain");
        check("b2b_rx_data", {24'd0, rx_data}, 32'h0000_00FF);

        // Reset in the middle of bit 4 of 8'h55, line low across release
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(((8'h55 >> i) & 8'h01) != 8'h00, CPB);
        drive(1'b1, CPB / 2);
        rst_n = 1'b0;
        rs232_rx = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("midrst");
        snap = int_high_total;
        rst_n = 1'b1;
        drive(1'b0, 40);
        check("midrst_no_false_start", int_high_total - snap, 32'd0);
        drive(1'b1, 20);
        check("midrst_idle_rx_data", {24'd0, rx_data}, 32'd0);

        // Clean 8'h12 after reset (two ones -> even parity bit 0)
        expect_ev(EV_VALID, 8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        drive(1'b1, 8);
        wait_drain("r12_drain");
        check("r12_rx_int_len", last_int_len, FRAME_INT_LEN);

`ifdef UART_RX_PARITY_EN
        // 8'h07 has three ones: parity bit 1 is correct, 0 is a mismatch
        expect_ev(EV_VALID, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        drive(1'b1, 8);
        wait_drain("par_good_drain");
        expect_ev(EV_PERR, 8'h00);
        send_frame(8'h07, 1'b1, 1'b0);
        drive(1'b1, 8);
        wait_drain("par_bad_drain");
        check("par_bad_rx_int_len", last_int_len, FRAME_INT_LEN);
        check("par_bad_rx_data_kept", {24'd0, rx_data}, 32'h0000_0007);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
